// File: rtl/tdm_pkg.sv
// Shared lane-count / slot-width definitions for the TDM mux and its matching demux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Both ends of the channel import this package so the lane count and the width
// of the slot index carried alongside each word can never drift apart.
package tdm_pkg;

    // Number of lanes serialised per frame and width of the slot index.
    localparam int NUM_LANES = 8;
    localparam int SLOT_W    = 3;

    // Index of the final slot in a frame; reaching its terminal count wraps.
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_LANES - 1);

    // Mux control FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Slot following s; only used where s is known not to be the last slot.
    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        return s + SLOT_W'(1);
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Hold/slot counter pair: counts HOLD_CYCLES cycles per slot, then steps the slot index.
// Latency: slot is a register; tc/wrap are combinational decodes of the current count.
// Backpressure: counting only happens while adv_en is high; otherwise both counters freeze.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears both counters)
//   adv_en    - one counting step on this edge
//   slot      - current slot index (registered)
//   tc        - hold counter is at its last cycle; the next step advances the slot
//   wrap      - tc in the last slot; the next step begins a new frame at slot 0
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_en,
    output logic [SLOT_W-1:0] slot,
    output logic              tc,
    output logic              wrap
);

    // A 1-bit counter is kept even for HOLD_CYCLES=1; it then simply sits at 0.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    assign tc   = (hold_q == HOLD_LAST);
    assign wrap = tc && (slot_q == LAST_SLOT);
    assign slot = slot_q;

    always_comb begin
        hold_d = hold_q;
        slot_d = slot_q;
        if (adv_en) begin
            if (tc) begin
                hold_d = '0;
                // Natural 3-bit rollover takes slot 7 back to slot 0 on wrap.
                slot_d = slot_q + SLOT_W'(1);
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            slot_q <= '0;
        end else begin
            hold_q <= hold_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/tdm_mux.sv
// 8-to-1 time-division mux: serialises eight snapshotted lanes round-robin onto Out with slot index S.
// Latency: lane value sampled at frame start appears on Out for slot i after i*HOLD_CYCLES edges.
// Backpressure: C4 low pauses the mux; Out/S/counters/snapshot freeze and valid drops until C4 returns.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset (highest priority)
//   C4           - run enable (1 = run, 0 = pause)
//   In0..In7     - lane inputs, sampled all together at each frame start
//   Out          - multiplexed data word (registered)
//   S            - slot index of the word on Out (registered)
//   valid        - Out/S carry a live slot this cycle
//   frame_start  - first cycle of slot 0 of each frame
//   P            - even parity of Out, present only when TDM_MUX_PARITY_EN is defined
module tdm_mux
    import tdm_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              C4,
    input  logic [WIDTH-1:0]  In0,
    input  logic [WIDTH-1:0]  In1,
    input  logic [WIDTH-1:0]  In2,
    input  logic [WIDTH-1:0]  In3,
    input  logic [WIDTH-1:0]  In4,
    input  logic [WIDTH-1:0]  In5,
    input  logic [WIDTH-1:0]  In6,
    input  logic [WIDTH-1:0]  In7,
    output logic [WIDTH-1:0]  Out,
    output logic [SLOT_W-1:0] S,
`ifdef TDM_MUX_PARITY_EN
    output logic              P,
`endif
    output logic              valid,
    output logic              frame_start
);

    // Lanes gathered into an array so snapshot and selection can be indexed.
    logic [WIDTH-1:0] lanes [NUM_LANES];

    assign lanes[0] = In0;
    assign lanes[1] = In1;
    assign lanes[2] = In2;
    assign lanes[3] = In3;
    assign lanes[4] = In4;
    assign lanes[5] = In5;
    assign lanes[6] = In6;
    assign lanes[7] = In7;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] snap_q [NUM_LANES];
    logic [WIDTH-1:0] snap_d [NUM_LANES];
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             fs_q, fs_d;
    logic             start_frame;
    logic             adv_en;
    logic [SLOT_W-1:0] slot;
    logic             tc;
    logic             wrap;

    // The slot/hold counters step only on edges that perform a RUN step,
    // including the resume edge out of PAUSE. A frame start out of IDLE does
    // not step them: they are already at slot 0, hold 0 after reset.
    assign adv_en = C4 && (state_q != IDLE);

    tdm_slot_ctr #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_slot_ctr (
        .clk    (clk),
        .rst    (rst),
        .adv_en (adv_en),
        .slot   (slot),
        .tc     (tc),
        .wrap   (wrap)
    );

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        out_d       = out_q;
        valid_d     = valid_q;
        fs_d        = 1'b0;
        start_frame = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (C4) begin
                    state_d     = RUN;
                    start_frame = 1'b1;
                end
            end
            RUN, PAUSE: begin
                if (!C4) begin
                    state_d = PAUSE;
                    valid_d = 1'b0;
                end else begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    if (wrap) begin
                        start_frame = 1'b1;
                    end else if (tc) begin
                        out_d = snap_q[next_slot(slot)];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Slot 0 is driven straight from the live In0 rather than the old
        // snapshot, so the frame's first word is the value sampled on this edge.
        if (start_frame) begin
            snap_d  = lanes;
            out_d   = lanes[0];
            valid_d = 1'b1;
            fs_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '{default: '0};
            out_q   <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
        end
    end

    assign Out         = out_q;
    assign S           = slot;
    assign valid       = valid_q;
    assign frame_start = fs_q;

`ifdef TDM_MUX_PARITY_EN
    // Parity tracks whatever is loaded into Out; when Out holds, so does P.
    logic p_q, p_d;

    always_comb begin
        p_d = ^out_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= 1'b0;
        end else begin
            p_q <= p_d;
        end
    end

    assign P = p_q;
`endif

endmodule

// File: tb/tb_tdm_mux.sv
module tb_tdm_mux;

    logic       clk;
    logic       rst1, rst3;
    logic       c4_1, c4_3;
    logic [3:0] lane [8];

    logic [3:0] o1, o3;
    logic [2:0] s1, s3;
    logic       v1, v3, f1, f3;
`ifdef TDM_MUX_PARITY_EN
    logic       p1, p3;
`endif

    int checks;
    int failures;

    typedef struct {
        string      tag;
        bit         dut3;
        logic [3:0] out;
        logic [2:0] s;
        logic       v;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];

    tdm_mux #(.WIDTH(4), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .C4(c4_1),
        .In0(lane[0]), .In1(lane[1]), .In2(lane[2]), .In3(lane[3]),
        .In4(lane[4]), .In5(lane[5]), .In6(lane[6]), .In7(lane[7]),
        .Out(o1), .S(s1),
`ifdef TDM_MUX_PARITY_EN
        .P(p1),
`endif
        .valid(v1), .frame_start(f1)
    );

    tdm_mux #(.WIDTH(4), .HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .C4(c4_3),
        .In0(lane[0]), .In1(lane[1]), .In2(lane[2]), .In3(lane[3]),
        .In4(lane[4]), .In5(lane[5]), .In6(lane[6]), .In7(lane[7]),
        .Out(o3), .S(s3),
`ifdef TDM_MUX_PARITY_EN
        .P(p3),
`endif
        .valid(v3), .frame_start(f3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input bit d3, input logic [3:0] o,
                        input logic [2:0] s, input logic v, input logic fs);
        exp_t e;
        e.tag  = tag;
        e.dut3 = d3;
        e.out  = o;
        e.s    = s;
        e.v    = v;
        e.fs   = fs;
        exp_q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [3:0] ao;
        logic [2:0] as;
        logic       av, af;
        ao = e.dut3 ? o3 : o1;
        as = e.dut3 ? s3 : s1;
        av = e.dut3 ? v3 : v1;
        af = e.dut3 ? f3 : f1;
        checks++;
        assert (ao === e.out) else begin
            failures++;
            $error("FAIL %s.Out got=%h want=%h", e.tag, ao, e.out);
        end
        checks++;
        assert (as === e.s) else begin
            failures++;
            $error("FAIL %s.S got=%0d want=%0d", e.tag, as, e.s);
        end
        checks++;
        assert (av === e.v) else begin
            failures++;
            $error("FAIL %s.valid got=%b want=%b", e.tag, av, e.v);
        end
        checks++;
        assert (af === e.fs) else begin
            failures++;
            $error("FAIL %s.frame_start got=%b want=%b", e.tag, af, e.fs);
        end
`ifdef TDM_MUX_PARITY_EN
        begin
            logic ap;
            ap = e.dut3 ? p3 : p1;
            checks++;
            assert (ap === ^e.out) else begin
                failures++;
                $error("FAIL %s.P got=%b want=%b", e.tag, ap, ^e.out);
            end
        end
`endif
    endtask

    // One clock edge, then compare every expectation queued for it.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst1 = 1'b1; rst3 = 1'b1;
        c4_1 = 1'b0; c4_3 = 1'b0;
        for (int i = 0; i < 8; i++) lane[i] = 4'(i + 1);

        tick();
        tick();
        push("rst_state1", 0, 4'h0, 3'd0, 1'b0, 1'b0);
        push("rst_state3", 1, 4'h0, 3'd0, 1'b0, 1'b0);
        tick();

        // IDLE with C4 low keeps reset values.
        rst1 = 1'b0;
        push("idle", 0, 4'h0, 3'd0, 1'b0, 1'b0);
        tick();

        // Test 1: HOLD_CYCLES=1, one word per edge; test 2 lane change at S=1.
        c4_1 = 1'b1;
        push("t1_s0", 0, 4'h1, 3'd0, 1'b1, 1'b1);
        tick();
        for (int s = 1; s < 8; s++) begin
            push($sformatf("t1_s%0d", s), 0, 4'(s + 1), 3'(s), 1'b1, 1'b0);
            tick();
            if (s == 1) lane[3] = 4'hF;
        end
        push("t1_wrap", 0, 4'h1, 3'd0, 1'b1, 1'b1);
        tick();
        push("t2_s1", 0, 4'h2, 3'd1, 1'b1, 1'b0); tick();
        push("t2_s2", 0, 4'h3, 3'd2, 1'b1, 1'b0); tick();
        push("t2_s3", 0, 4'hF, 3'd3, 1'b1, 1'b0); tick();
        push("t2_s4", 0, 4'h5, 3'd4, 1'b1, 1'b0); tick();

        // Test 3: pause three cycles at S=4.
        c4_1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push($sformatf("t3_pause%0d", k), 0, 4'h5, 3'd4, 1'b0, 1'b0);
            tick();
        end
        c4_1 = 1'b1;
        push("t3_resume", 0, 4'h6, 3'd5, 1'b1, 1'b0); tick();
        push("t5_s6", 0, 4'h7, 3'd6, 1'b1, 1'b0); tick();

        // Test 5: reset at S=6 with C4 high, then restart with fresh lanes.
        rst1 = 1'b1;
        push("t5_rst", 0, 4'h0, 3'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) lane[i] = 4'(8 - i);
        rst1 = 1'b0;
        push("t5_restart", 0, 4'h8, 3'd0, 1'b1, 1'b1); tick();
        push("t5_s1", 0, 4'h7, 3'd1, 1'b1, 1'b0); tick();

        // Test 6: parity pattern (P is compared whenever the port exists).
        rst1 = 1'b1;
        tick();
        lane[0] = 4'b0110;
        lane[1] = 4'b0111;
        rst1 = 1'b0;
        push("t6_s0", 0, 4'b0110, 3'd0, 1'b1, 1'b1); tick();
        push("t6_s1", 0, 4'b0111, 3'd1, 1'b1, 1'b0); tick();

        // Test 4: HOLD_CYCLES=3, 24-cycle frame.
        rst1 = 1'b1;
        c4_1 = 1'b0;
        for (int i = 0; i < 8; i++) lane[i] = 4'(i + 1);
        rst3 = 1'b0;
        c4_3 = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 3; k++) begin
                push($sformatf("t4_s%0d_c%0d", s, k), 1, 4'(s + 1), 3'(s), 1'b1,
                     (s == 0 && k == 0) ? 1'b1 : 1'b0);
                tick();
            end
        end
        push("t4_wrap", 1, 4'h1, 3'd0, 1'b1, 1'b1);
        tick();

        // Pause inside slot 0: resume must not re-assert frame_start.
        c4_3 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push($sformatf("t4_pause%0d", k), 1, 4'h1, 3'd0, 1'b0, 1'b0);
            tick();
        end
        c4_3 = 1'b1;
        push("t4_resume_c1", 1, 4'h1, 3'd0, 1'b1, 1'b0); tick();
        push("t4_resume_c2", 1, 4'h1, 3'd0, 1'b1, 1'b0); tick();
        push("t4_after_s1", 1, 4'h2, 3'd1, 1'b1, 1'b0); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
